// File: rtl/fetch_pkg.sv
`default_nettype none
// ============================================================================
// Module   : fetch_pkg
// Purpose  : Shared constants, FSM state type and IF/ID payload for fetch.
// Revision : 1.0
// ============================================================================
package fetch_pkg;

   localparam int          PC_W       = 8;
   localparam int          IMEM_DEPTH = 64;
   localparam logic [31:0] NOP_INSTR  = 32'h0000_0000;

   typedef enum logic [0:0] {
      RUN  = 1'b0,
      HALT = 1'b1
   } fetch_state_t;

   typedef struct packed {
      logic [31:0]     instr;
      logic [PC_W-1:0] pc;
      logic [PC_W-1:0] pc_plus1;
      logic            valid;
   } if_id_t;

   localparam if_id_t IF_ID_BUBBLE = '{
      instr    : NOP_INSTR,
      pc       : '0,
      pc_plus1 : '0,
      valid    : 1'b0
   };

endpackage
`default_nettype wire

// File: rtl/fetch_if.sv
`default_nettype none
// ============================================================================
// Module   : fetch_if
// Purpose  : IMEM, hazard/redirect and IF/ID outputs of the fetch stage.
// Revision : 1.0
// ============================================================================
interface fetch_if #(
   parameter int PC_W  = 8,
   parameter int CNT_W = 16
);
   logic [PC_W-1:0]  fetch_pc;
   logic [31:0]      fetch_instruction;
   logic             stall;
   logic             redirect;
   logic [PC_W-1:0]  redirect_target;
   logic [31:0]      id_instruction;
   logic [PC_W-1:0]  id_pc;
   logic [PC_W-1:0]  id_pc_plus1;
   logic             id_valid;
   logic             fetch_halted;
   logic [CNT_W-1:0] fetch_count;

   modport master (
      output fetch_pc,
      input  fetch_instruction,
      input  stall,
      input  redirect,
      input  redirect_target,
      output id_instruction,
      output id_pc,
      output id_pc_plus1,
      output id_valid,
      output fetch_halted,
      output fetch_count
   );

   modport slave (
      input  fetch_pc,
      output fetch_instruction,
      output stall,
      output redirect,
      output redirect_target,
      input  id_instruction,
      input  id_pc,
      input  id_pc_plus1,
      input  id_valid,
      input  fetch_halted,
      input  fetch_count
   );

endinterface
`default_nettype wire

// File: rtl/fetch_if_id_reg.sv
`default_nettype none
// ============================================================================
// Module   : if_id_reg
// Purpose  : Generic pipeline register with hold, flush-to-bubble and async reset.
// Revision : 1.0
// ============================================================================
module if_id_reg #(
   parameter int           W      = 1,
   parameter logic [W-1:0] BUBBLE = '0
) (
   input  wire logic         clk,
   input  wire logic         reset,
   input  wire logic         i_hold,
   input  wire logic         i_flush,
   input  wire logic [W-1:0] i_d,
   output logic      [W-1:0] o_q
);

   logic [W-1:0] r_q;

   // Flush wins over hold so a redirect can squash a stalled slot.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_q <= BUBBLE;
      end else if (i_flush) begin
         r_q <= BUBBLE;
      end else if (!i_hold) begin
         r_q <= i_d;
      end
   end

   assign o_q = r_q;

endmodule
`default_nettype wire

// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : fetch_unit
// Purpose  : PC, RUN/HALT FSM, delivered-instruction counter and IF/ID register.
// Revision : 1.0
// ============================================================================
module fetch_unit
   import fetch_pkg::*;
#(
   parameter int PC_W       = fetch_pkg::PC_W,
   parameter int IMEM_DEPTH = fetch_pkg::IMEM_DEPTH,
   parameter int CNT_W      = 16
) (
   input  wire logic clk,
   input  wire logic reset,
   fetch_if.master   bus
);

   fetch_state_t     r_state;
   fetch_state_t     w_next_state;
   logic [PC_W-1:0]  r_pc;
   logic [PC_W-1:0]  w_next_pc;
   logic [PC_W-1:0]  w_pc_plus1;
   logic [CNT_W-1:0] r_count;
   logic             w_count_en;
   logic             w_in_range;
   logic             w_hold;
   logic             w_flush;
   if_id_t           w_d;
   if_id_t           w_q;

   assign w_pc_plus1 = r_pc + PC_W'(1);
   assign w_in_range = (int'(r_pc) < IMEM_DEPTH);

   // Priority: redirect, then HALT bubbles, then stall, then advance/halt.
   always_comb begin
      w_next_state = r_state;
      w_next_pc    = r_pc;
      w_hold       = 1'b1;
      w_flush      = 1'b0;
      w_count_en   = 1'b0;
      w_d          = IF_ID_BUBBLE;
      if (bus.redirect) begin
         w_next_pc    = bus.redirect_target;
         w_flush      = 1'b1;
         w_next_state = RUN;
      end else if (r_state == HALT) begin
         w_flush = 1'b1;
      end else if (!bus.stall) begin
         if (w_in_range) begin
            w_d.instr    = bus.fetch_instruction;
            w_d.pc       = r_pc;
            w_d.pc_plus1 = w_pc_plus1;
            w_d.valid    = 1'b1;
            w_hold       = 1'b0;
            w_next_pc    = w_pc_plus1;
            w_count_en   = 1'b1;
         end else begin
            w_flush      = 1'b1;
            w_next_state = HALT;
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state <= RUN;
         r_pc    <= '0;
         r_count <= '0;
      end else begin
         r_state <= w_next_state;
         r_pc    <= w_next_pc;
         if (w_count_en && !(&r_count)) begin
            r_count <= r_count + CNT_W'(1);
         end
      end
   end

   if_id_reg #(
      .W      ($bits(if_id_t)),
      .BUBBLE (IF_ID_BUBBLE)
   ) u_if_id_reg (
      .clk     (clk),
      .reset   (reset),
      .i_hold  (w_hold),
      .i_flush (w_flush),
      .i_d     (w_d),
      .o_q     (w_q)
   );

   assign bus.fetch_pc       = r_pc;
   assign bus.id_instruction = w_q.instr;
   assign bus.id_pc          = w_q.pc;
   assign bus.id_pc_plus1    = w_q.pc_plus1;
   assign bus.id_valid       = w_q.valid;
   assign bus.fetch_halted   = (r_state == HALT);
   assign bus.fetch_count    = r_count;

endmodule
`default_nettype wire

// File: doc/fetch_unit.md
# fetch_unit

Instruction-fetch stage that drives the word-index address into the combinational instruction memory (IMEM) and registers the returned instruction into the IF/ID pipeline register for the decode stage. It owns the program counter and applies stall, branch/jump redirect, and flush from later stages. It halts cleanly when the PC leaves the 64-word IMEM range.

## Interface
Parameters:
- PC_W, 8, PC width; PC is a word index, not a byte address.
- IMEM_DEPTH, 64, number of valid IMEM words.
- CNT_W, 16, width of the delivered-instruction counter.

Ports:
- clk  in  1  sole clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- fetch_pc  out  PC_W  current PC, wired to IMEM_PC.
- fetch_instruction  in  32  IMEM_instruction for fetch_pc; combinational, same cycle.
- stall  in  1  hazard unit: hold the PC and the IF/ID register.
- redirect  in  1  EX stage: branch taken or jump.
- redirect_target  in  PC_W  new PC (word index) when redirect=1.
- id_instruction  out  32  registered instruction to decode.
- id_pc  out  PC_W  PC of id_instruction.
- id_pc_plus1  out  PC_W  id_pc+1 (mod 2^PC_W), used as the link value.
- id_valid  out  1  id_instruction is real, not a bubble.
- fetch_halted  out  1  FSM is in HALT.
- fetch_count  out  CNT_W  number of instructions delivered to ID (saturating).

## Operation
- FSM states: RUN, HALT. Reset state is RUN.
- Each cycle is resolved in this priority order: reset, redirect, stall, advance.
- Redirect (either state):
  - PC <= redirect_target.
  - IF/ID is flushed: id_valid<=0, id_instruction<=32'h0000_0000 (NOP).
  - State becomes RUN.
  - Redirect overrides stall in the same cycle.
- Stall (RUN, no redirect): PC, IF/ID, and fetch_count all hold.
- Advance (RUN, no stall, no redirect):
  - If fetch_pc < IMEM_DEPTH:
    - IF/ID <= {fetch_instruction, fetch_pc, fetch_pc+1, valid=1}.
    - PC <= PC+1.
    - fetch_count increments, saturating at all-ones.
  - If fetch_pc >= IMEM_DEPTH:
    - No capture; IF/ID gets a bubble (id_valid=0, NOP).
    - PC holds.
    - State becomes HALT.
- HALT without redirect:
  - PC holds.
  - id_valid=0 every cycle.
  - stall is ignored.
  - fetch_halted=1.
- fetch_instruction is never sampled while fetch_pc >= IMEM_DEPTH, because the IMEM output is undefined there.
- PC arithmetic is modulo 2^PC_W. The wrap itself is unreachable, since the halt triggers at IMEM_DEPTH.

## Timing
- Reset values:
  - PC=0, fetch_pc=0.
  - id_instruction=0, id_pc=0, id_pc_plus1=0, id_valid=0.
  - fetch_halted=0, fetch_count=0, state=RUN.
- Fetch-to-decode latency is 1 cycle. After reset deasserts, the first edge gives id_instruction=ins[0], id_pc=0, id_pc_plus1=1, id_valid=1, fetch_pc=1.
- fetch_pc is a direct register output with no combinational path from the inputs.
- Redirect penalty:
  - The edge after redirect shows a bubble.
  - The next edge delivers ins[redirect_target].
- A redirect out of HALT resumes fetch exactly as in RUN.
- A redirect to a target >= IMEM_DEPTH loads the PC, then halts on the following advance edge.
- Reset asserted mid-operation clears all state immediately (asynchronously). Fetch restarts at PC=0 on the first edge after deassertion.

## Structure
- Shared package fetch_pkg holds:
  - IMEM_DEPTH and PC_W constants.
  - NOP_INSTR = 32'h0000_0000.
  - fetch_state_t enum {RUN, HALT}.
  - if_id_t struct {instr, pc, pc_plus1, valid}.
- Sub-module if_id_reg: the IF/ID register, with hold (stall) and flush (redirect) inputs, asynchronous reset to a bubble. It is reusable by the later ID/EX register.
- The fetch_unit top level holds the PC register, the FSM, the counter, and the priority logic.

## Test plan
- Reset, then 4 free-running cycles with IMEM words 0..3 = 0x20080001, 0x20090002, 0x01095020, 0x0 -> id_pc goes 0,1,2,3; id_instruction matches each word; id_valid=1; fetch_count=4.
- stall held for 3 cycles at PC=2 -> fetch_pc stays 2; IF/ID stays {ins[1], pc 1}; fetch_count unchanged. On release, ins[2] is delivered next edge.
- redirect=1 with target=10 in the same cycle as stall=1 -> next edge: fetch_pc=10, id_valid=0. Following edge: id_instruction=ins[10], id_pc=10, id_pc_plus1=11.
- Run to PC=63 -> ins[63] is delivered, fetch_pc=64. Next edge: fetch_halted=1, id_valid=0, PC holds 64. A later redirect to target=5 -> fetch_halted=0, and ins[5] appears two edges after the redirect.
- reset asserted asynchronously, between edges, while PC=20 and fetch_count=20 -> all outputs go to reset values immediately. After release, the first edge delivers ins[0].
- Force fetch_count to near saturation (CNT_W=4 build), then run 20 cycles -> count sticks at 15 and never wraps to 0.
